// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a word-wide, byte-lane data RAM.
// One request in flight; big-endian lanes (sel[3] / data[31:24] is byte offset 0).
module lsu_mem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_wd,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_wd,
    output logic              resp_wreg,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              stall_req,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_sel,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i
);
    typedef enum logic [3:0] {
        OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LW = 4'd4,
        OP_SB = 4'd8, OP_SH  = 4'd9, OP_SW = 4'd10
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    state_e            r_state, w_next;
    op_e               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [4:0]        r_wd;
    logic [31:0]       r_rdata;
    logic              r_wreg, r_adel, r_ades;

    logic              w_legal, w_half, w_word, w_misaligned, w_accept, w_kill;
    logic [ADDR_W-1:0] w_addr_fix;
    logic [7:0]        w_byte;
    logic [15:0]       w_hword;
    logic [31:0]       w_load_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_legal = 1'b0;
        w_half  = 1'b0;
        w_word  = 1'b0;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: w_legal = 1'b1;
            OP_LH, OP_LHU, OP_SH: begin w_legal = 1'b1; w_half = 1'b1; end
            OP_LW, OP_SW:         begin w_legal = 1'b1; w_word = 1'b1; end
            default:              w_legal = 1'b0;
        endcase
        w_misaligned = (w_half & req_addr[0]) | (w_word & (|req_addr[1:0]));
        // Without alignment checking the offending low address bits are simply dropped.
        w_addr_fix = req_addr;
        if (!ALIGN_CHECK && w_half) w_addr_fix[0]   = 1'b0;
        if (!ALIGN_CHECK && w_word) w_addr_fix[1:0] = 2'b00;
    end

    assign w_kill    = flush | rst;
    assign req_ready = (r_state == S_IDLE) & ~flush;
    assign w_accept  = req_ready & req_valid & w_legal;
    assign stall_req = (r_state != S_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = (ALIGN_CHECK && w_misaligned) ? S_RESP : S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    // RAM port is live only in ACCESS, and a flush/reset drops the access in the same cycle.
    always_comb begin
        mem_ce     = (r_state == S_ACCESS) & ~w_kill;
        mem_we     = mem_ce & r_op[3];
        mem_addr   = '0;
        mem_sel    = 4'b0000;
        mem_data_o = 32'h0;
        if (mem_ce) begin
            mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
            case (r_op)
                OP_SB:   begin mem_sel = 4'b1000 >> r_addr[1:0]; mem_data_o = {4{r_wdata[7:0]}};  end
                OP_SH:   begin mem_sel = r_addr[1] ? 4'b0011 : 4'b1100; mem_data_o = {2{r_wdata[15:0]}}; end
                OP_SW:   begin mem_sel = 4'b1111; mem_data_o = r_wdata; end
                default: mem_sel = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_data_i[31:24];
            2'd1:    w_byte = mem_data_i[23:16];
            2'd2:    w_byte = mem_data_i[15:8];
            default: w_byte = mem_data_i[7:0];
        endcase
        w_hword = r_addr[1] ? mem_data_i[15:0] : mem_data_i[31:16];
        case (r_op)
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'h0, w_byte};
            OP_LH:   w_load_data = {{16{w_hword[15]}}, w_hword};
            OP_LHU:  w_load_data = {16'h0, w_hword};
            OP_LW:   w_load_data = mem_data_i;
            default: w_load_data = 32'h0;
        endcase
    end

    assign resp_valid = (r_state == S_RESP) & ~w_kill;
    assign resp_rdata = resp_valid ? r_rdata : 32'h0;
    assign resp_wd    = resp_valid ? r_wd    : 5'h0;
    assign resp_wreg  = resp_valid & r_wreg;
    assign exc_adel   = resp_valid & r_adel;
    assign exc_ades   = resp_valid & r_ades;

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_LB;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_wd    <= 5'h0;
            r_rdata <= 32'h0;
            r_wreg  <= 1'b0;
            r_adel  <= 1'b0;
            r_ades  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= op_e'(req_op);
                r_addr  <= w_addr_fix;
                r_wdata <= req_wdata;
                r_wd    <= req_wd;
                r_rdata <= 32'h0;
                r_wreg  <= 1'b0;
                r_adel  <= ALIGN_CHECK && w_misaligned && !req_op[3];
                r_ades  <= ALIGN_CHECK && w_misaligned &&  req_op[3];
            end else if (r_state == S_ACCESS && !flush) begin
                r_rdata <= r_op[3] ? 32'h0 : w_load_data;
                r_wreg  <= ~r_op[3];
            end
        end
    end

endmodule
